fsub_issue_ctrl: RTL and testbench

//  Initiator/collector for the 2-stage pipelined FP subtract unit (fsub_p2).
//  - Accepts valid/ready requests from the core and drives x1/x2 into the unit.
//  - Tracks in-flight ops with a tag shift register and captures y/ovf into a result FIFO.
//  - Returns {y, tag, ovf} to the core over a valid/ready response port.
//  - The unit has no stall input, so issue is credit-gated: a captured result never lacks a FIFO slot.

---
 rtl/fsub_issue_ctrl.sv | 152 +++++++++++++++
 tb/tb_fsub_issue_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsub_issue_ctrl.sv
// Issue/collect controller for the fsub_p2 pipelined FP subtract unit.
// Credit-gated issue, tag shift register, result FIFO and status flags.
module fsub_issue_ctrl #(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_x1,
  input  logic [31:0]      req_x2,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      fu_x1,
  output logic [31:0]      fu_x2,
  input  logic [31:0]      fu_y,
  input  logic             fu_ovf,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_y,
  output logic [TAG_W-1:0] resp_tag,
  output logic             resp_ovf,
  output logic             ovf_sticky,
  input  logic             ovf_clr,
  output logic             busy
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IW = $clog2(LATENCY + 1);

  typedef struct packed {
    logic [31:0]      y;
    logic [TAG_W-1:0] tag;
    logic             ovf;
  } ent_t;

  logic [CW-1:0]      credits;
  logic [CW-1:0]      count;
  logic [PW-1:0]      wptr;
  logic [PW-1:0]      rptr;
  logic [LATENCY-1:0] vq;
  logic [TAG_W-1:0]   tq [LATENCY];
  ent_t               mem [DEPTH];
  ent_t               head;
  logic [IW-1:0]      inflight;
  logic               fire;
  logic               pop;
  logic               capture;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign req_ready  = rstn & (credits != '0);
  assign fire       = req_valid & req_ready;
  assign resp_valid = (count != '0);
  assign pop        = resp_valid & resp_ready;
  assign capture    = vq[LATENCY-1];
  assign fu_x1      = req_x1;
  assign fu_x2      = req_x2;

  // Head is forced to zero when empty so reset shows clean outputs.
  assign head     = resp_valid ? mem[rptr] : '0;
  assign resp_y   = head.y;
  assign resp_tag = head.tag;
  assign resp_ovf = head.ovf;

  // Credits: one per FIFO slot not yet claimed by an in-flight or held op.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      credits <= CW'(DEPTH);
    end else if (fire && !pop) begin
      credits <= credits - 1'b1;
    end else if (pop && !fire) begin
      credits <= credits + 1'b1;
    end
  end

  // Valid/tag shift register tracking ops inside the unit.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < LATENCY; i++) begin
        vq[i] <= 1'b0;
        tq[i] <= '0;
      end
    end else begin
      vq[0] <= fire;
      tq[0] <= req_tag;
      for (int i = 1; i < LATENCY; i++) begin
        vq[i] <= vq[i-1];
        tq[i] <= tq[i-1];
      end
    end
  end

  // Result storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (rstn && capture) begin
      mem[wptr] <= '{y: fu_y, tag: tq[LATENCY-1], ovf: fu_ovf};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (capture) wptr <= nxt(wptr);
      if (pop)     rptr <= nxt(rptr);
      unique case ({capture, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow; a new overflow beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ovf_sticky <= 1'b0;
    end else if (capture && fu_ovf) begin
      ovf_sticky <= 1'b1;
    end else if (ovf_clr) begin
      ovf_sticky <= 1'b0;
    end
  end

  // Count of ops still inside the unit.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) begin
      inflight = inflight + IW'(vq[i]);
    end
  end

  assign busy = (inflight != '0) | (count != '0);

`ifndef SYNTHESIS
  // Credits should make a push into a full FIFO impossible.
  always_ff @(posedge clk) begin
    if (rstn && capture) begin
      assert (count != CW'(DEPTH));
    end
  end
`endif

endmodule

// File: tb/tb_fsub_issue_ctrl.sv
// Directed bench for fsub_issue_ctrl.
// Includes a 2-stage behavioural stand-in for fsub_p2.
module tb_fsub_issue_ctrl;

  localparam int TAG_W = 5;

  typedef struct {
    logic [31:0]      x1;
    logic [31:0]      x2;
    logic [TAG_W-1:0] tag;
  } req_t;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [31:0]      req_x1 = '0;
  logic [31:0]      req_x2 = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic [31:0]      fu_x1;
  logic [31:0]      fu_x2;
  logic [31:0]      fu_y;
  logic             fu_ovf;
  logic             resp_valid;
  logic             resp_ready = 1'b0;
  logic [31:0]      resp_y;
  logic [TAG_W-1:0] resp_tag;
  logic             resp_ovf;
  logic             ovf_sticky;
  logic             ovf_clr = 1'b0;
  logic             busy;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fire = 0;
  int n_pop  = 0;

  req_t        req_q[$];
  logic [37:0] sb[$];

  always #5 clk = ~clk;

  fsub_issue_ctrl #(
    .LATENCY(2),
    .DEPTH(4),
    .TAG_W(TAG_W)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_x1(req_x1),
    .req_x2(req_x2),
    .req_tag(req_tag),
    .fu_x1(fu_x1),
    .fu_x2(fu_x2),
    .fu_y(fu_y),
    .fu_ovf(fu_ovf),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_y(resp_y),
    .resp_tag(resp_tag),
    .resp_ovf(resp_ovf),
    .ovf_sticky(ovf_sticky),
    .ovf_clr(ovf_clr),
    .busy(busy)
  );

  // Hand-computed results for the directed operands; others get a marker.
  function automatic logic [32:0] fu_f(input logic [31:0] a,
                                       input logic [31:0] b);
    if (a == 32'h3F800000 && b == 32'h3F000000)
      return {32'h3F000000, 1'b0};
    if (a == 32'h7F7FFFFF && b == 32'hFF7FFFFF)
      return {32'h7F800000, 1'b1};
    if (a == 32'h7F800000 && b == 32'h7F800000)
      return {32'hFFC00000, 1'b0};
    return {a ^ b, 1'b0};
  endfunction

  // Two-register stand-in for fsub_p2.
  logic [32:0] s1, s2;
  always @(posedge clk) begin
    if (!rstn) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= fu_f(fu_x1, fu_x2);
      s2 <= s1;
    end
  end
  assign fu_y   = s2[32:1];
  assign fu_ovf = s2[0];

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [37:0] expect_of(input req_t r);
    logic [32:0] yo;
    yo = fu_f(r.x1, r.x2);
    return {yo[32:1], r.tag, yo[0]};
  endfunction

  task automatic push_req(input logic [31:0] a,
                          input logic [31:0] b,
                          input int t);
    req_t r;
    r.x1  = a;
    r.x2  = b;
    r.tag = TAG_W'(t);
    req_q.push_back(r);
  endtask

  // One clock: present queue head, sample mid-cycle, step, score.
  task automatic cyc();
    req_t        r;
    logic        f;
    logic        p;
    logic [37:0] got;
    r = '{default: '0};
    if (req_q.size() != 0) begin
      r         = req_q[0];
      req_valid = 1'b1;
      req_x1    = r.x1;
      req_x2    = r.x2;
      req_tag   = r.tag;
    end else begin
      req_valid = 1'b0;
    end
    #4;
    f   = req_valid & req_ready;
    p   = resp_valid & resp_ready;
    got = {resp_y, resp_tag, resp_ovf};
    @(posedge clk);
    #1;
    if (f) begin
      r = req_q.pop_front();
      sb.push_back(expect_of(r));
      n_fire++;
    end
    if (p) begin
      n_pop++;
      chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) chk("resp", 64'(got), 64'(sb.pop_front()));
    end
  endtask

  task automatic drain();
    resp_ready = 1'b1;
    for (int i = 0; i < 60 && (req_q.size() + sb.size()) != 0; i++)
      cyc();
    chk("drain_done", 64'(req_q.size() + sb.size()), 64'd0);
  endtask

  initial begin
    // Reset
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready_low", 64'(req_ready), 64'd0);
    rstn = 1'b1;
    #1;
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_rvalid", 64'(resp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_sticky", 64'(ovf_sticky), 64'd0);
    chk("rst_head", 64'({resp_y, resp_tag, resp_ovf}), 64'd0);

    // 1. Single op latency
    push_req(32'h3F800000, 32'h3F000000, 3);
    cyc();
    chk("t1_rv_t", 64'(resp_valid), 64'd0);
    chk("t1_busy", 64'(busy), 64'd1);
    cyc();
    chk("t1_rv_t1", 64'(resp_valid), 64'd0);
    cyc();
    chk("t1_rv_t2", 64'(resp_valid), 64'd1);
    chk("t1_y", 64'(resp_y), 64'h3F000000);
    chk("t1_tag", 64'(resp_tag), 64'd3);
    chk("t1_ovf", 64'(resp_ovf), 64'd0);
    resp_ready = 1'b1;
    cyc();
    resp_ready = 1'b0;
    chk("t1_rv_pop", 64'(resp_valid), 64'd0);
    chk("t1_idle", 64'(busy), 64'd0);

    // 2. Backpressure: only DEPTH ops accepted
    n_fire = 0;
    n_pop  = 0;
    for (int i = 0; i < 6; i++)
      push_req(32'h40000000 + i, 32'h11 * i, 10 + i);
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("t2_ready", 64'(req_ready), 64'(i < 3));
    end
    chk("t2_fires", 64'(n_fire), 64'd4);
    chk("t2_pending", 64'(req_q.size()), 64'd2);
    chk("t2_credits", 64'(dut.credits), 64'd0);
    chk("t2_count", 64'(dut.count), 64'd4);
    drain();
    chk("t2_pops", 64'(n_pop), 64'd6);

    // 3. Streaming at one op per cycle
    n_fire = 0;
    for (int i = 0; i < 12; i++)
      push_req(32'h12345000 + i, 32'h00ABC000 + 3 * i, i);
    resp_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (i == 6) chk("t3_credits", 64'(dut.credits), 64'd1);
    end
    chk("t3_fires", 64'(n_fire), 64'd12);
    drain();

    // 3b. Full FIFO, then pop alone, then fire with pop
    resp_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      push_req(32'h0F000000 + i, 32'h1, 20 + i);
    for (int i = 0; i < 6; i++) cyc();
    chk("t3_full_cnt", 64'(dut.count), 64'd4);
    chk("t3_full_cr", 64'(dut.credits), 64'd0);
    chk("t3_full_rdy", 64'(req_ready), 64'd0);
    push_req(32'h0E000000, 32'h2, 24);
    n_fire = 0;
    resp_ready = 1'b1;
    cyc();
    chk("t3_pop_cr", 64'(dut.credits), 64'd1);
    chk("t3_pop_cnt", 64'(dut.count), 64'd3);
    chk("t3_pop_nofire", 64'(n_fire), 64'd0);
    cyc();
    chk("t3_fp_cr", 64'(dut.credits), 64'd1);
    chk("t3_fp_fire", 64'(n_fire), 64'd1);
    drain();

    // 4. Overflow and sticky flag
    push_req(32'h7F7FFFFF, 32'hFF7FFFFF, 7);
    drain();
    chk("t4_sticky", 64'(ovf_sticky), 64'd1);
    ovf_clr = 1'b1;
    cyc();
    ovf_clr = 1'b0;
    chk("t4_clr", 64'(ovf_sticky), 64'd0);
    resp_ready = 1'b0;
    push_req(32'h7F7FFFFF, 32'hFF7FFFFF, 8);
    cyc();
    cyc();
    ovf_clr = 1'b1;
    cyc();
    ovf_clr = 1'b0;
    chk("t4_set_wins", 64'(ovf_sticky), 64'd1);
    ovf_clr = 1'b1;
    cyc();
    ovf_clr = 1'b0;
    chk("t4_clr2", 64'(ovf_sticky), 64'd0);
    drain();

    // 5. Inf - Inf gives the default NaN
    push_req(32'h7F800000, 32'h7F800000, 9);
    drain();
    chk("t5_sticky", 64'(ovf_sticky), 64'd0);

    // 6. Reset with two ops in flight and two buffered
    resp_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      push_req(32'h3F800000, 32'h3F000000, 16 + i);
    for (int i = 0; i < 4; i++) cyc();
    chk("t6_pre_cnt", 64'(dut.count), 64'd2);
    chk("t6_pre_busy", 64'(busy), 64'd1);
    rstn      = 1'b0;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    req_q.delete();
    sb.delete();
    #1;
    chk("t6_rvalid", 64'(resp_valid), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_credits", 64'(dut.credits), 64'd4);
    chk("t6_ready", 64'(req_ready), 64'd1);
    resp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t6_no_stale", 64'(resp_valid), 64'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
